// File: rtl/alu_nbit_pkg.sv
// alu_nbit_pkg: opcodes and FSM state encoding for alu_nbit_seq.
// Defining ALU_NBIT_DIV_EN adds the DIV state used by the iterative divider.
package alu_nbit_pkg;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_MOD  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_EQ   = 4'h7;
  localparam logic [3:0] OP_LAND = 4'h8;
  localparam logic [3:0] OP_LOR  = 4'h9;
  localparam logic [3:0] OP_SHR  = 4'hA;
  localparam logic [3:0] OP_SHL  = 4'hB;
  localparam logic [3:0] OP_XOR  = 4'hC;
  localparam logic [3:0] OP_NOT  = 4'hD;
  localparam logic [3:0] OP_CAT  = 4'hE;
  localparam logic [3:0] OP_DUPA = 4'hF;
`ifdef ALU_NBIT_DIV_EN
  typedef enum logic [1:0] {IDLE, EXEC, DIV, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
`endif
  function automatic logic is_div_op(input logic [3:0] op);
    return op == OP_DIV || op == OP_MOD;
  endfunction
endpackage

// File: rtl/alu_div_iter.sv
// alu_div_iter: unsigned restoring divider, one quotient bit per cycle.
// The first bit is resolved on the start edge, so done rises WIDTH-1 cycles later.
module alu_div_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] r_q, r_d, q_q, q_d, d_q, d_d, r_src, q_src, d_src;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d;
  logic [WIDTH:0] trial;
  assign done = busy_q && cnt_q == CW'(WIDTH);
  assign busy = busy_q;
  assign quotient = q_q;
  assign remainder = r_q;
  always_comb begin
    r_src = start ? '0 : r_q;
    q_src = start ? dividend : q_q;
    d_src = start ? divisor : d_q;
    trial = {r_src, q_src[WIDTH-1]} - {1'b0, d_src};
    r_d = r_q;
    q_d = q_q;
    d_d = d_q;
    cnt_d = cnt_q;
    busy_d = busy_q && !done;
    if (start || (busy_q && !done)) begin
      r_d = trial[WIDTH] ? {r_src[WIDTH-2:0], q_src[WIDTH-1]} : trial[WIDTH-1:0];
      q_d = {q_src[WIDTH-2:0], ~trial[WIDTH]};
      d_d = d_src;
      cnt_d = start ? CW'(1) : cnt_q + CW'(1);
      busy_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_q <= '0;
      q_q <= '0;
      d_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
    end else begin
      r_q <= r_d;
      q_q <= q_d;
      d_q <= d_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
    end
endmodule

// File: rtl/alu_nbit_seq.sv
// alu_nbit_seq: handshaked sequential ALU, 2-cycle ops plus optional iterative div/mod.
// Define ALU_NBIT_DIV_EN to build the divider; otherwise opcodes 3/4 return 0 with err.
module alu_nbit_seq
  import alu_nbit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         alu_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] alu_out,
  output logic               c_out,
  output logic               zero,
  output logic               err
);
  localparam int W2 = 2 * WIDTH;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, shl, inv;
  logic [3:0] op_q, op_d;
  logic [W2-1:0] res_q, res_d, res;
  logic c_q, c_d, err_q, err_d, res_c, res_err;
  logic [WIDTH:0] sum, dif;
`ifdef ALU_NBIT_DIV_EN
  logic start, div_busy, div_done;
  logic [WIDTH-1:0] quo, rem;
  assign in_ready = state_q == IDLE && !div_busy;
  assign start = in_valid && in_ready && is_div_op(alu_sel) && b != '0;
  alu_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(a), .divisor(b),
    .busy(div_busy), .done(div_done), .quotient(quo), .remainder(rem)
  );
`else
  assign in_ready = state_q == IDLE;
`endif
  assign out_valid = state_q == DONE;
  assign alu_out = res_q;
  assign c_out = c_q;
  assign zero = out_valid && res_q == '0;
  assign err = out_valid && err_q;
  always_comb begin
    sum = {1'b0, a_q} + {1'b0, b_q};
    dif = {1'b0, a_q} - {1'b0, b_q};
    shl = a_q << 2;
    inv = ~a_q;
    res = '0;
    res_c = 1'b0;
    res_err = 1'b0;
    case (op_q)
      OP_ADD:  begin res = W2'(sum[WIDTH-1:0]); res_c = sum[WIDTH]; end
      OP_SUB:  begin res = W2'(dif[WIDTH-1:0]); res_c = dif[WIDTH]; end
      OP_MUL:  res = W2'(a_q) * W2'(b_q);
`ifdef ALU_NBIT_DIV_EN
      // Only divide-by-zero reaches EXEC for div/mod
      OP_DIV:  begin res = W2'({WIDTH{1'b1}}); res_err = 1'b1; end
      OP_MOD:  begin res = W2'(a_q); res_err = 1'b1; end
`else
      OP_DIV, OP_MOD: res_err = 1'b1;
`endif
      OP_AND:  res = W2'(a_q & b_q);
      OP_OR:   res = W2'(a_q | b_q);
      OP_EQ:   res = W2'(a_q == b_q);
      OP_LAND: res = W2'(a_q != '0 && b_q != '0);
      OP_LOR:  res = W2'(a_q != '0 || b_q != '0);
      OP_SHR:  res = W2'(a_q >> 2);
      OP_SHL:  res = W2'(shl);
      OP_XOR:  res = W2'(a_q ^ b_q);
      OP_NOT:  res = W2'(inv);
      OP_CAT:  res = {a_q, b_q};
      OP_DUPA: res = {a_q, a_q};
      default: res = '0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    res_d = res_q;
    c_d = c_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (in_valid && in_ready) begin
        a_d = a;
        b_d = b;
        op_d = alu_sel;
`ifdef ALU_NBIT_DIV_EN
        state_d = start ? DIV : EXEC;
`else
        state_d = EXEC;
`endif
      end
      EXEC: begin
        res_d = res;
        c_d = res_c;
        err_d = res_err;
        state_d = DONE;
      end
`ifdef ALU_NBIT_DIV_EN
      DIV: if (div_done) begin
        res_d = W2'(op_q == OP_DIV ? quo : rem);
        c_d = 1'b0;
        err_d = 1'b0;
        state_d = DONE;
      end
`endif
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      res_q <= '0;
      c_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      res_q <= res_d;
      c_q <= c_d;
      err_q <= err_d;
    end
endmodule
